pipeline_data_ram: RTL and testbench

- Parametrised single-port data memory for the pipelined MIPS CPU. Sits in the MEM stage in place of the earlier fixed-size, word-only data memory.
- Adds byte, halfword and word access with sign or zero extension, and a registered read with 1-cycle latency.
- Adds a valid/ready request handshake and error reporting for misaligned, out-of-range and bad-size accesses.
- Optional post-reset clear engine.

---
 rtl/pipeline_data_ram.sv | 125 ++++++++++++
 tb/tb_pipeline_data_ram.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_data_ram.sv
// MEM-stage data RAM: byte/half/word access, load data registered 1 cycle after accept, errors pulse alongside.
// Backpressure: req_ready is always 1, except that with DMEM_CLEAR_EN defined it stays 0 while the array is zeroed.
module pipeline_data_ram #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              rd_valid,
    output logic [31:0]       rdata,
    output logic              err,
    output logic [1:0]        err_code
);
    localparam logic [ADDR_W-3:0] DEPTH_IDX = (ADDR_W-2)'(DEPTH);

    logic [31:0]      mem [DEPTH];
    logic             accept;
    logic [1:0]       code;
    logic [1:0]       lane;
    logic [IDX_W-1:0] idx;
    logic [3:0]       be;
    logic [31:0]      wd;
    logic [31:0]      shifted;
    logic [31:0]      ext;
    logic             clr_we;
    logic [IDX_W-1:0] clr_cnt;

    assign accept = req_valid && req_ready;
    assign lane   = addr[1:0];
    assign idx    = addr[IDX_W+1:2];

    always_comb begin
        code = 2'b00;
        if (req_size == 2'b11)
            code = 2'b11;
        else if ((req_size == 2'b01 && addr[0]) || (req_size == 2'b10 && lane != 2'b00))
            code = 2'b01;
        else if (addr[ADDR_W-1:2] >= DEPTH_IDX)
            code = 2'b10;
    end

    always_comb begin
        case (req_size)
            2'b00:   begin be = 4'b0001 << lane;                    wd = {4{wdata[7:0]}};  end
            2'b01:   begin be = addr[1] ? 4'b1100 : 4'b0011;        wd = {2{wdata[15:0]}}; end
            default: begin be = 4'b1111;                            wd = wdata;            end
        endcase
    end

    // Lane select and extension happen before the register so rdata is final one cycle after accept.
    always_comb begin
        shifted = mem[idx] >> {lane, 3'b000};
        case (req_size)
            2'b00:   ext = {{24{~req_unsigned & shifted[7]}},  shifted[7:0]};
            2'b01:   ext = {{16{~req_unsigned & shifted[15]}}, shifted[15:0]};
            default: ext = shifted;
        endcase
    end

`ifdef DMEM_CLEAR_EN
    typedef enum logic {S_CLEAR, S_IDLE} state_t;
    localparam logic [IDX_W-1:0] CLR_LAST = IDX_W'(DEPTH - 1);
    state_t state, state_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_CLEAR;
            clr_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_CLEAR)
                clr_cnt <= clr_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == S_CLEAR && clr_cnt == CLR_LAST)
            state_nxt = S_IDLE;
    end

    always_comb begin
        req_ready = (state == S_IDLE);
        clr_we    = (state == S_CLEAR);
    end
`else
    assign req_ready = 1'b1;
    assign clr_we    = 1'b0;
    assign clr_cnt   = '0;
`endif

    // Array has no reset value; reset in the sensitivity list only blocks a write on an edge seen under reset.
    always_ff @(posedge clk or negedge reset) begin
        if (reset) begin
            if (clr_we)
                mem[clr_cnt] <= '0;
            else if (accept && req_wr && code == 2'b00)
                for (int i = 0; i < 4; i++)
                    if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_valid <= 1'b0;
            rdata    <= '0;
            err      <= 1'b0;
            err_code <= 2'b00;
        end else begin
            rd_valid <= accept && !req_wr;
            err      <= accept && (code != 2'b00);
            err_code <= accept ? code : 2'b00;
            if (accept && !req_wr)
                rdata <= (code == 2'b00) ? ext : 32'h0;
        end
    end
endmodule

// File: tb/tb_pipeline_data_ram.sv
// Scoreboarded random bench for pipeline_data_ram against a byte-array reference model.
module tb_pipeline_data_ram;
    localparam int DEPTH  = 256;
    localparam int ADDR_W = 32;

    logic              clk;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              rd_valid;
    logic [31:0]       rdata;
    logic              err;
    logic [1:0]        err_code;

    pipeline_data_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_wr(req_wr), .req_size(req_size), .req_unsigned(req_unsigned),
        .addr(addr), .wdata(wdata), .rd_valid(rd_valid), .rdata(rdata),
        .err(err), .err_code(err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic        rv;
        logic [31:0] rd;
        logic        e;
        logic [1:0]  ec;
    } exp_t;

    exp_t       q[$];
    int         errors = 0;
    int         checks = 0;
    logic [7:0] mdl [DEPTH*4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [1:0] mdl_code(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'b11) return 2'b11;
        if ((sz == 2'b01 && (a % 2) != 0) || (sz == 2'b10 && (a % 4) != 0)) return 2'b01;
        if ((a / 4) >= DEPTH) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [31:0] mdl_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
        int n;
        logic [31:0] v;
        n = nbytes(sz);
        v = 32'h0;
        for (int i = 0; i < n; i++)
            v = v | (32'(mdl[int'(a) + i]) << (8 * i));
        if (!uns && n < 4 && v[8*n-1])
            v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    // Expected responses are due in the cycle after the accepting edge.
    task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
        logic [1:0] c;
        exp_t e;
        c = mdl_code(sz, a);
        chk("req_ready_on_issue", {31'b0, req_ready}, 32'd1);
        if (!wr || c != 2'b00) begin
            e.due = cyc + 1;
            e.rv  = !wr;
            e.rd  = (!wr && c == 2'b00) ? mdl_load(a, sz, uns) : 32'h0;
            e.e   = (c != 2'b00);
            e.ec  = c;
            q.push_back(e);
        end
        if (wr && c == 2'b00)
            for (int i = 0; i < nbytes(sz); i++)
                mdl[int'(a) + i] = 8'(wd >> (8 * i));
        req_valid = 1'b1; req_wr = wr; req_size = sz; req_unsigned = uns; addr = a; wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0 && q[0].due < cyc) begin
            e = q.pop_front();
            checks++; errors++;
            $display("FAIL missing_response due cycle %0d, now %0d", e.due, cyc);
        end
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk("rd_valid", {31'b0, rd_valid}, {31'b0, e.rv});
            chk("err", {31'b0, err}, {31'b0, e.e});
            chk("err_code", {30'b0, err_code}, {30'b0, e.ec});
            if (e.rv) chk("rdata", rdata, e.rd);
        end else begin
            chk("idle_rd_valid", {31'b0, rd_valid}, 32'd0);
            chk("idle_err", {31'b0, err}, 32'd0);
        end
    end

`ifdef DMEM_CLEAR_EN
    task automatic count_ready(output int n);
        n = 0;
        for (int k = 0; k < 4 * DEPTH; k++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (req_ready) break;
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int          n;
        logic [31:0] a;
        logic [1:0]  sz;
        logic        wr;
        int          r;
        reset = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; addr = '0; wdata = '0;
        for (int i = 0; i < DEPTH * 4; i++) mdl[i] = 8'h00;
        #2;
        chk("reset_rd_valid", {31'b0, rd_valid}, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_err", {31'b0, err}, 32'd0);
        chk("reset_err_code", {30'b0, err_code}, 32'd0);
`ifdef DMEM_CLEAR_EN
        chk("reset_req_ready", {31'b0, req_ready}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        count_ready(n);
        chk("clear_cycles", n, DEPTH);
        @(posedge clk); #1;
        for (int w = 0; w < DEPTH; w++) issue(1'b0, 2'b10, 1'b0, 32'(4 * w), 32'h0);
        idle(3);
        @(negedge clk) reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (100) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        chk("clear_restart_ready", {31'b0, req_ready}, 32'd0);
        @(negedge clk) reset = 1'b1;
        count_ready(n);
        chk("clear_cycles_restart", n, DEPTH);
        @(posedge clk); #1;
`else
        chk("reset_req_ready", {31'b0, req_ready}, 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
`endif
        for (int w = 0; w < DEPTH; w++) issue(1'b1, 2'b10, 1'b0, 32'(4 * w), $urandom);

        issue(1'b0, 2'b10, 1'b0, 32'h10, 0);
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 0);
        idle(1);
        issue(1'b1, 2'b00, 1'b0, 32'h13, 32'h5A);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 0);
        issue(1'b0, 2'b00, 1'b0, 32'h13, 0);
        issue(1'b0, 2'b00, 1'b0, 32'h12, 0);
        issue(1'b0, 2'b00, 1'b1, 32'h12, 0);
        issue(1'b0, 2'b01, 1'b0, 32'h11, 0);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 0);
        issue(1'b1, 2'b10, 1'b0, 32'(4 * DEPTH), 32'h1234_5678);
        issue(1'b0, 2'b10, 1'b0, 32'(4 * DEPTH), 0);
        issue(1'b1, 2'b11, 1'b0, 32'h10, 32'hFFFF_FFFF);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 0);
        issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h1);
        issue(1'b0, 2'b10, 1'b0, 32'h20, 0);
        issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h2);
        issue(1'b0, 2'b10, 1'b0, 32'h20, 0);
        issue(1'b0, 2'b01, 1'b0, 32'h22, 0);
        issue(1'b0, 2'b01, 1'b1, 32'h12, 0);

        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 7) == 0) idle(1);
            r  = int'($urandom_range(0, 7));
            sz = (r == 7) ? 2'b11 : 2'(r % 3);
            wr = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 4 * DEPTH + 7));
            if ($urandom_range(0, 3) != 0 && sz != 2'b11) a = a & ~32'(nbytes(sz) - 1);
            issue(wr, sz, 1'($urandom_range(0, 1)), a, $urandom);
        end

`ifndef DMEM_CLEAR_EN
        // Store presented on an edge seen under reset must not land.
        idle(2);
        req_valid = 1'b1; req_wr = 1'b1; req_size = 2'b10; addr = 32'h30; wdata = 32'hCAFE_F00D;
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        issue(1'b0, 2'b10, 1'b0, 32'h30, 0);
`endif
        idle(5);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL leftover_responses: got %0d pending, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
